// File: rtl/bnn_conv_pkg.sv
// Shared types and constants for the binary 3x3 convolution engine.
// Build option: BNN_PROG_THRESH_EN (threshold loaded from weight memory word 0).
package bnn_conv_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD_W,
    S_HDR,
    S_FILL,
    S_CONV,
    S_WRITE
  } state_t;

  localparam int HDR_N_LSB = 0;
  localparam int HDR_N_MSB = 4;
  localparam logic [7:0] SENTINEL = 8'hFF;
  localparam logic [3:0] DEFAULT_THRESH = 4'd5;
  localparam int MAX_K = 8;
  localparam int WIN_BITS = 9;

  function automatic bit num_k_ok(input int k);
    return (k >= 1) && (k <= MAX_K);
  endfunction

endpackage

// File: rtl/bnn_xnor_pe.sv
// One output pixel for one kernel: XNOR of weights and window, popcount,
// and compare against the threshold.
module bnn_xnor_pe
  import bnn_conv_pkg::*;
(
  input  logic [WIN_BITS-1:0] weights,
  input  logic [WIN_BITS-1:0] window,
  input  logic [3:0]          thresh,
  output logic                match
);

  logic [WIN_BITS-1:0] agree;
  logic [3:0]          ones;

  always_comb begin
    agree = ~(weights ^ window);
    ones  = '0;
    for (int i = 0; i < WIN_BITS; i++) begin
      ones = ones + {3'b000, agree[i]};
    end
    match = (ones >= thresh);
  end

endmodule

// File: rtl/bnn_conv_engine.sv
// Streams binary images from SRAM, applies NUM_K 3x3 binary kernels and writes
// one thresholded output row per kernel. Build option: BNN_PROG_THRESH_EN.
module bnn_conv_engine
  import bnn_conv_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 12,
  parameter int NUM_K  = 4
) (
  input  logic              clk,
  input  logic              reset_b,
  input  logic              dut_run,
  output logic              dut_busy,
  output logic [ADDR_W-1:0] dut_sram_read_address,
  input  logic [DATA_W-1:0] sram_dut_read_data,
  output logic [ADDR_W-1:0] dut_sram_write_address,
  output logic [DATA_W-1:0] dut_sram_write_data,
  output logic              dut_sram_write_enable,
  output logic [ADDR_W-1:0] dut_wmem_read_address,
  input  logic [DATA_W-1:0] wmem_dut_read_data
);

  localparam int COLS = DATA_W - 2;
  localparam logic [3:0] K4 = 4'(NUM_K);
`ifdef BNN_PROG_THRESH_EN
  localparam logic [3:0] LD_FIRST = 4'd0;
`else
  localparam logic [3:0] LD_FIRST = 4'd1;
`endif

  generate
    if (!num_k_ok(NUM_K)) begin : g_bad_num_k
      $error("bnn_conv_engine: NUM_K must be 1..%0d", MAX_K);
    end
  endgenerate

  state_t state, state_nx;

  logic [ADDR_W-1:0] rd_ptr, wr_ptr;
  logic [3:0]        ld_cnt, ld_pa;
  logic              ld_pv;
  logic              hdr_ph;
  logic [1:0]        fill_cnt;
  logic              pend;
  logic [4:0]        n_reg, out_row;
  logic [2:0]        k_idx;

  logic [DATA_W-1:0]            row0, row1, row2;
  logic [NUM_K-1:0][8:0]        kern;
  logic [NUM_K-1:0][COLS-1:0]   res;
  logic [NUM_K-1:0][COLS-1:0]   out_reg;
  logic [COLS-1:0]              col_mask;
  logic [COLS-1:0]              wr_word;
  logic [3:0]                   thresh;

  logic [4:0] hdr_n;
  logic       hdr_end;
  logic       last_row;
  logic       last_k;

  assign hdr_n    = sram_dut_read_data[HDR_N_MSB:HDR_N_LSB];
  assign hdr_end  = (sram_dut_read_data[7:0] == SENTINEL) || (hdr_n < 5'd3) ||
                    (int'(hdr_n) > DATA_W);
  assign last_row = (out_row == (n_reg - 5'd3));
  assign last_k   = (k_idx == 3'(NUM_K - 1));

  always_ff @(posedge clk or posedge reset_b) begin
    if (reset_b) state <= S_IDLE;
    else         state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:   if (dut_run) state_nx = S_LOAD_W;
      S_LOAD_W: if (ld_pv && (ld_pa == K4)) state_nx = S_HDR;
      S_HDR:    if (hdr_ph) state_nx = hdr_end ? S_IDLE : S_FILL;
      S_FILL:   if (pend && (fill_cnt == 2'd3)) state_nx = S_CONV;
      S_CONV:   if (!pend) state_nx = S_WRITE;
      S_WRITE:  if (last_k) state_nx = last_row ? S_HDR : S_CONV;
      default:  state_nx = S_IDLE;
    endcase
  end

  // Sequencing counters; pend marks that the SRAM word arriving this cycle is an image row.
  always_ff @(posedge clk or posedge reset_b) begin
    if (reset_b) begin
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      ld_cnt   <= '0;
      ld_pa    <= '0;
      ld_pv    <= 1'b0;
      hdr_ph   <= 1'b0;
      fill_cnt <= '0;
      pend     <= 1'b0;
      n_reg    <= '0;
      out_row  <= '0;
      k_idx    <= '0;
    end else begin
      pend  <= 1'b0;
      ld_pv <= 1'b0;
      case (state)
        S_IDLE: begin
          rd_ptr <= '0;
          wr_ptr <= '0;
          ld_cnt <= LD_FIRST;
          hdr_ph <= 1'b0;
          k_idx  <= '0;
        end
        S_LOAD_W: begin
          if (ld_cnt <= K4) begin
            ld_pv  <= 1'b1;
            ld_pa  <= ld_cnt;
            ld_cnt <= ld_cnt + 4'd1;
          end
        end
        S_HDR: begin
          if (!hdr_ph) begin
            rd_ptr <= rd_ptr + 1'b1;
            hdr_ph <= 1'b1;
          end else begin
            hdr_ph   <= 1'b0;
            n_reg    <= hdr_n;
            fill_cnt <= '0;
            out_row  <= '0;
            if (hdr_end) begin
              rd_ptr <= '0;
              wr_ptr <= '0;
            end
          end
        end
        S_FILL: begin
          if (fill_cnt != 2'd3) begin
            rd_ptr   <= rd_ptr + 1'b1;
            fill_cnt <= fill_cnt + 2'd1;
            pend     <= 1'b1;
          end
        end
        S_CONV: k_idx <= '0;
        S_WRITE: begin
          wr_ptr <= wr_ptr + 1'b1;
          if ((k_idx == 3'd0) && !last_row) begin
            rd_ptr <= rd_ptr + 1'b1;
            pend   <= 1'b1;
          end
          if (last_k) begin
            k_idx   <= '0;
            out_row <= out_row + 5'd1;
          end else begin
            k_idx <= k_idx + 3'd1;
          end
        end
        default: ;
      endcase
    end
  end

  // Datapath registers carry no reset; write data is gated until a WRITE pass.
  always_ff @(posedge clk) begin
    if (pend) begin
      row0 <= row1;
      row1 <= row2;
      row2 <= sram_dut_read_data;
    end
    if (ld_pv) begin
      for (int k = 0; k < NUM_K; k++) begin
        if (ld_pa == 4'(k + 1)) kern[k] <= wmem_dut_read_data[8:0];
      end
    end
    if ((state == S_CONV) && !pend) out_reg <= res & {NUM_K{col_mask}};
  end

`ifdef BNN_PROG_THRESH_EN
  logic [3:0] thresh_q;
  always_ff @(posedge clk) begin
    if (ld_pv && (ld_pa == 4'd0)) thresh_q <= wmem_dut_read_data[3:0];
  end
  assign thresh = thresh_q;
`else
  assign thresh = DEFAULT_THRESH;
`endif

  generate
    for (genvar k = 0; k < NUM_K; k++) begin : g_kern
      for (genvar c = 0; c < COLS; c++) begin : g_col
        bnn_xnor_pe u_pe (
          .weights (kern[k]),
          .window  ({row2[c+2:c], row1[c+2:c], row0[c+2:c]}),
          .thresh  (thresh),
          .match   (res[k][c])
        );
      end
    end
  endgenerate

  always_comb begin
    col_mask = '0;
    for (int c = 0; c < COLS; c++) begin
      col_mask[c] = ((c + 2) < int'(n_reg));
    end
  end

  always_comb begin
    wr_word = '0;
    for (int k = 0; k < NUM_K; k++) begin
      if (k_idx == 3'(k)) wr_word = out_reg[k];
    end
  end

  logic unused_wmem;
  assign unused_wmem = &{1'b0, wmem_dut_read_data[DATA_W-1:9]};

  always_comb begin
    dut_wmem_read_address = '0;
    if (state == S_LOAD_W) begin
      dut_wmem_read_address = (ld_cnt <= K4) ? ADDR_W'(ld_cnt) : ADDR_W'(K4);
    end
  end

  assign dut_busy               = (state != S_IDLE);
  assign dut_sram_read_address  = rd_ptr;
  assign dut_sram_write_address = wr_ptr;
  assign dut_sram_write_enable  = (state == S_WRITE);
  assign dut_sram_write_data    = dut_sram_write_enable ? {2'b00, wr_word} : '0;

endmodule

// File: tb/tb_bnn_conv_engine.sv
// Directed bench for bnn_conv_engine with NUM_K = 2 and separate input/output memories.
module tb_bnn_conv_engine;

  localparam int DW = 16;
  localparam int AW = 12;
  localparam int NK = 2;
  localparam int EW = AW + DW;

  logic          clk = 1'b0;
  logic          reset_b = 1'b0;
  logic          dut_run = 1'b0;
  logic          dut_busy;
  logic [AW-1:0] dut_sram_read_address;
  logic [DW-1:0] sram_dut_read_data;
  logic [AW-1:0] dut_sram_write_address;
  logic [DW-1:0] dut_sram_write_data;
  logic          dut_sram_write_enable;
  logic [AW-1:0] dut_wmem_read_address;
  logic [DW-1:0] wmem_dut_read_data;

  logic [DW-1:0] sram [0:4095];
  logic [DW-1:0] wmem [0:4095];
  logic [EW-1:0] exp_q[$];
  logic [EW-1:0] act_q[$];
  int n_cmp = 0;
  int n_bad = 0;
  int sp = 0;
  int cyc;
  bit found;

  bnn_conv_engine #(.DATA_W(DW), .ADDR_W(AW), .NUM_K(NK)) dut (
    .clk                    (clk),
    .reset_b                (reset_b),
    .dut_run                (dut_run),
    .dut_busy               (dut_busy),
    .dut_sram_read_address  (dut_sram_read_address),
    .sram_dut_read_data     (sram_dut_read_data),
    .dut_sram_write_address (dut_sram_write_address),
    .dut_sram_write_data    (dut_sram_write_data),
    .dut_sram_write_enable  (dut_sram_write_enable),
    .dut_wmem_read_address  (dut_wmem_read_address),
    .wmem_dut_read_data     (wmem_dut_read_data)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    sram_dut_read_data <= sram[dut_sram_read_address];
    wmem_dut_read_data <= wmem[dut_wmem_read_address];
  end

  always @(negedge clk) begin
    if (dut_sram_write_enable) act_q.push_back({dut_sram_write_address, dut_sram_write_data});
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic clear_sram();
    for (int i = 0; i < 4096; i++) sram[i] = '0;
    sp = 0;
  endtask

  task automatic put_word(input logic [DW-1:0] w);
    sram[sp] = w;
    sp++;
  endtask

  function automatic int t_model();
`ifdef BNN_PROG_THRESH_EN
    return int'(wmem[0][3:0]);
`else
    return 5;
`endif
  endfunction

  // Reference convolution straight from the image layout in sram[] and kernels in wmem[].
  function automatic void build_model();
    int a  = 0;
    int wa = 0;
    exp_q.delete();
    for (int img = 0; img < 16; img++) begin
      logic [DW-1:0] h = sram[a];
      int n = int'(h[4:0]);
      if (h[7:0] == 8'hFF || n < 3 || n > DW) break;
      for (int r = 0; r <= n - 3; r++) begin
        for (int k = 0; k < NK; k++) begin
          logic [DW-1:0] d = '0;
          logic [8:0] w = wmem[1 + k][8:0];
          for (int c = 0; c <= n - 3; c++) begin
            logic [8:0] win;
            for (int i = 0; i < 3; i++) begin
              win[i]     = sram[a + 1 + r][c + i];
              win[3 + i] = sram[a + 2 + r][c + i];
              win[6 + i] = sram[a + 3 + r][c + i];
            end
            d[c] = ($countones(~(w ^ win)) >= t_model());
          end
          exp_q.push_back({AW'(wa), d});
          wa++;
        end
      end
      a += n + 1;
    end
  endfunction

  // Checkerboard image of test 2: mode 0 = T 5 pattern, 1 = all ones, 2 = all zeros.
  task automatic hand_t2(input int mode);
    exp_q.delete();
    for (int i = 0; i < 16; i++) begin
      logic [DW-1:0] d;
      if (mode == 1)      d = 16'h00FF;
      else if (mode == 2) d = 16'h0000;
      else                d = (((i / 2) % 2) == (i % 2)) ? 16'h0055 : 16'h00AA;
      exp_q.push_back({AW'(i), d});
    end
  endtask

  task automatic load_t2();
    clear_sram();
    put_word(16'd10);
    for (int r = 0; r < 10; r++) put_word((r % 2 == 0) ? 16'h0155 : 16'h02AA);
    put_word(16'h00FF);
    wmem[1] = 16'h0155;
    wmem[2] = 16'h00AA;
  endtask

  task automatic compare_q(input string tag);
    int m;
    chk($sformatf("%s count", tag), act_q.size(), exp_q.size());
    m = (act_q.size() < exp_q.size()) ? act_q.size() : exp_q.size();
    for (int i = 0; i < m; i++) chk($sformatf("%s w%0d", tag, i), act_q[i], exp_q[i]);
  endtask

  task automatic run_job(input string tag, input bit pulse_mid, output int ncyc);
    act_q.delete();
    @(negedge clk) dut_run = 1'b1;
    @(negedge clk) dut_run = 1'b0;
    chk({tag, " busy_rise"}, dut_busy, 1);
    ncyc = 1;
    while (dut_busy && ncyc < 4000) begin
      dut_run = (pulse_mid && ncyc == 20);
      @(negedge clk);
      ncyc++;
    end
    dut_run = 1'b0;
    chk({tag, " busy_fall"}, dut_busy, 0);
    chk({tag, " rd_addr_idle"}, dut_sram_read_address, 0);
    chk({tag, " wr_addr_idle"}, dut_sram_write_address, 0);
    repeat (4) @(negedge clk);
    chk({tag, " stays_idle"}, dut_busy, 0);
  endtask

  initial begin
    for (int i = 0; i < 4096; i++) wmem[i] = '0;
    clear_sram();
    #2 reset_b = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst busy", dut_busy, 0);
    chk("rst rd_addr", dut_sram_read_address, 0);
    chk("rst wr_addr", dut_sram_write_address, 0);
    chk("rst wdata", dut_sram_write_data, 0);
    chk("rst we", dut_sram_write_enable, 0);
    chk("rst wmem_addr", dut_wmem_read_address, 0);
    reset_b = 1'b0;
    @(negedge clk);

    // Test 1: all-ones 16x16, k0 matches everything, k1 matches nothing.
    wmem[0] = 16'd5;
    wmem[1] = 16'h01FF;
    wmem[2] = 16'h0000;
    clear_sram();
    put_word(16'd16);
    for (int r = 0; r < 16; r++) put_word(16'hFFFF);
    put_word(16'h00FF);
    exp_q.delete();
    for (int r = 0; r < 14; r++) begin
      exp_q.push_back({AW'(2 * r), 16'h3FFF});
      exp_q.push_back({AW'(2 * r + 1), 16'h0000});
    end
    run_job("t1", 1'b0, cyc);
    compare_q("t1");

    // Test 2: checkerboard rows with matching/complementary kernels.
    load_t2();
    hand_t2(0);
    run_job("t2", 1'b0, cyc);
    compare_q("t2");

    // Test 4: threshold 0 and 10 from word 0.
    wmem[0] = 16'd0;
`ifdef BNN_PROG_THRESH_EN
    hand_t2(1);
`else
    hand_t2(0);
`endif
    run_job("t4_t0", 1'b0, cyc);
    compare_q("t4_t0");
    wmem[0] = 16'd10;
`ifdef BNN_PROG_THRESH_EN
    hand_t2(2);
`else
    hand_t2(0);
`endif
    run_job("t4_t10", 1'b0, cyc);
    compare_q("t4_t10");
    wmem[0] = 16'd5;

    // Test 3: two random images back to back, dut_run pulsed mid-job.
    clear_sram();
    wmem[1] = 16'($urandom_range(0, 511));
    wmem[2] = 16'($urandom_range(0, 511));
    put_word(16'd12);
    for (int r = 0; r < 12; r++) put_word(16'($urandom_range(0, 16'hFFFF)));
    put_word(16'd10);
    for (int r = 0; r < 10; r++) put_word(16'($urandom_range(0, 16'hFFFF)));
    put_word(16'h00FF);
    build_model();
    run_job("t3", 1'b1, cyc);
    chk("t3 total_writes", act_q.size(), 36);
    compare_q("t3");

    // Test 5: reset during the third write, then rerun.
    load_t2();
    act_q.delete();
    found = 1'b0;
    @(negedge clk) dut_run = 1'b1;
    @(negedge clk) dut_run = 1'b0;
    for (int i = 0; i < 500 && !found; i++) begin
      @(posedge clk);
      #1;
      if (dut_sram_write_enable && act_q.size() == 2) found = 1'b1;
    end
    chk("t5 third_write_seen", found, 1);
    reset_b = 1'b1;
    #1;
    chk("t5 rst we", dut_sram_write_enable, 0);
    chk("t5 rst busy", dut_busy, 0);
    chk("t5 rst wdata", dut_sram_write_data, 0);
    chk("t5 rst wr_addr", dut_sram_write_address, 0);
    chk("t5 rst rd_addr", dut_sram_read_address, 0);
    repeat (2) @(negedge clk);
    reset_b = 1'b0;
    repeat (3) @(negedge clk);
    chk("t5 writes_before_abort", act_q.size(), 2);
    hand_t2(0);
    run_job("t5_rerun", 1'b0, cyc);
    compare_q("t5_rerun");

    // Test 6: headers that end the job at once.
    clear_sram();
    put_word(16'd2);
    for (int r = 0; r < 4; r++) put_word(16'hFFFF);
    run_job("t6_n2", 1'b0, cyc);
    chk("t6_n2 writes", act_q.size(), 0);
    chk("t6_n2 short_busy", (cyc <= 10), 1);
    clear_sram();
    put_word(16'd17);
    for (int r = 0; r < 17; r++) put_word(16'hFFFF);
    run_job("t6_n17", 1'b0, cyc);
    chk("t6_n17 writes", act_q.size(), 0);
    clear_sram();
    put_word(16'h12FF);
    run_job("t6_sent", 1'b0, cyc);
    chk("t6_sent writes", act_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
